// File: rtl/mul_iter_fsm.sv
// Iterative shift-add multiplier (MULT/MULTU) on the EX-stage data_valid/res_valid handshake.
// Sign is handled by multiplying magnitudes and negating the final product.
module mul_iter_fsm #(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 data_valid,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic                 out_ready,
    output logic                 res_valid,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   mult_out
);

    localparam int STEPS = WIDTH / ITER_BITS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      mult_out_q, mult_out_d;

    logic [WIDTH:0]     mag1;
    logic [WIDTH-1:0]   mag2;
    logic [ACC_W-1:0]   acc_sum;
    logic [PW-1:0]      final_mag;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            neg_q      <= 1'b0;
            mult_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            neg_q      <= neg_d;
            mult_out_q <= mult_out_d;
        end
    end

    // The magnitude of the most negative value still fits as unsigned, so mag2 needs no extra bit.
    always_comb begin
        mag1 = (is_signed && src1[WIDTH-1]) ? ((WIDTH+1)'(0) - {src1[WIDTH-1], src1})
                                             : {1'b0, src1};
        mag2 = (is_signed && src2[WIDTH-1]) ? (WIDTH'(0) - src2) : src2;
    end

    always_comb begin
        acc_sum = acc_q;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (mplier_q[i]) acc_sum = acc_sum + (mcand_q << i);
        end
        final_mag = acc_sum[PW-1:0];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        neg_d      = neg_q;
        mult_out_d = mult_out_q;
        case (state_q)
            S_IDLE: begin
                if (data_valid && !flush) begin
                    state_d  = S_CALC;
                    mcand_d  = ACC_W'(mag1);
                    mplier_d = mag2;
                    neg_d    = is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_W'(STEPS - 1);
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << ITER_BITS;
                    mplier_d = mplier_q >> ITER_BITS;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d    = S_DONE;
                        mult_out_d = neg_q ? (PW'(0) - final_mag) : final_mag;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status decoded straight from state so an async reset clears it before the next edge.
    always_comb begin
        res_valid = (state_q == S_DONE);
        busy      = (state_q == S_CALC);
        mult_out  = mult_out_q;
    end

endmodule

// File: doc/mul_iter_fsm.md
Name: mul_iter_fsm

Overview:
Multi-cycle iterative multiplier that responds to the EX-stage ALU's data_valid/res_valid handshake, the same protocol the ALU uses with its divider units.
- Replaces the combinational mult/multu array on the timing-critical EX path.
- The ALU drives the operands and request. It stalls with (data_valid & ~res_valid) and writes {hi,lo} from mult_out when res_valid is high.
- Handles MULT (signed) and MULTU (unsigned) with a 64-bit product.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
ITER_BITS, 1, multiplier bits consumed per CALC cycle (1 or 2); WIDTH must be divisible by ITER_BITS.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous, active-low reset.
flush  input  1  exception/ERET flush; aborts any operation in progress.
data_valid  input  1  request; held high by the ALU while a mult/multu occupies EX.
is_signed  input  1  1 = MULT, 0 = MULTU; sampled with the operands.
src1  input  WIDTH  multiplicand.
src2  input  WIDTH  multiplier.
out_ready  input  1  EX allowed to advance; result is consumed when res_valid & out_ready.
res_valid  output  1  mult_out holds a valid product.
busy  output  1  high in CALC.
mult_out  output  2*WIDTH  product {hi,lo}.

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE.
  - res_valid=0, busy=0, mult_out=0, iteration counter=0.
  - Takes effect immediately, including mid-CALC or in DONE; no partial result survives.
- States: IDLE, CALC, DONE.
- IDLE:
  - On data_valid & ~flush, latch src1, src2 and is_signed, then go to CALC.
  - In the latch cycle:
    - mag1 = |src1| and mag2 = |src2| (33-bit absolute value when signed, so 0x80000000 is exact); raw operands when unsigned.
    - neg = is_signed & (src1[31] ^ src2[31]).
    - Accumulator cleared; counter = WIDTH/ITER_BITS - 1.
- CALC:
  - Each cycle: add mag1 shifted into position times the low ITER_BITS of the multiplier into the accumulator, shift the multiplier right by ITER_BITS, decrement the counter.
  - When the counter is 0, go to DONE. The final value is written to mult_out as the accumulator, two's-complement negated if neg.
  - Changes on src1/src2/is_signed/data_valid during CALC are ignored.
- DONE:
  - res_valid=1 and mult_out stable.
  - Hold while out_ready=0 (other pipeline stall); no recompute.
  - On out_ready=1, go to IDLE. mult_out keeps its value; res_valid drops the next cycle.
- Latency: accept at cycle T; res_valid first high at T+1+WIDTH/ITER_BITS. Default: T+33.
- Back-to-back: after the DONE->IDLE handoff, a data_valid still high in IDLE is a new instruction and starts immediately. Minimum issue interval is 2+WIDTH/ITER_BITS cycles.
- Flush:
  - In any state, next state is IDLE and res_valid=0 next cycle.
  - Flush beats data_valid in the same cycle, so no start occurs.
  - mult_out is not cleared.
- busy=1 only in CALC. res_valid and busy are never both 1.
- Zero operands follow the normal path; no early termination, so latency is constant.
- Width rules: accumulator 2*WIDTH+2 bits internal; output truncated to 2*WIDTH; negation modulo 2^(2*WIDTH).

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, out_ready=1 -> res_valid exactly 33 cycles after accept, mult_out=0xFFFFFFFE_00000001, res_valid high for 1 cycle.
- MULT -3 (0xFFFFFFFD) * 7 -> mult_out=0xFFFFFFFF_FFFFFFEB. MULT 0x80000000 * 0x80000000 -> 0x40000000_00000000. MULT 0x80000000 * 1 -> 0xFFFFFFFF_80000000.
- Operand churn: src1/src2 randomized every cycle during CALC after accepting 6 * 9 -> mult_out=0x00000000_00000036.
- Held result: out_ready=0 for 10 cycles in DONE -> res_valid stays 1, mult_out stable, no restart; out_ready=1 -> IDLE next cycle. A second request (5 * 5 unsigned) held high starts immediately -> 0x19.
- Flush at CALC cycle 10 with data_valid high -> IDLE, res_valid never asserted. A new request 2 cycles later completes with the correct product and full 33-cycle latency.
- resetn low asynchronously mid-CALC and in DONE -> res_valid=0, busy=0, mult_out=0 before the next clk edge. Release plus request -> normal operation.
